// File: rtl/game_state_ctrl.sv
// game_state_ctrl
// Central MENU/RUN/PAUSE/OVER controller for the arena game. It takes the
// collide flags from the food and enemy position blocks plus the start and
// pause buttons. It drives the one-hot mode lines back to those blocks and
// keeps score, lives and the player radius.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   btn_start      start/restart button (debounced, level)
//   btn_pause      pause toggle button (debounced, level)
//   food_collide   food collide flag (level, one slow tick long)
//   enemy_collide  enemy collide flags, bit i = enemy i+1
//   gamemenu       mode line: MENU
//   gamerun        mode line: RUN
//   gamepause      mode line: PAUSE (all mode lines low in OVER)
//   score          foods eaten this game (saturates at 255)
//   lives          remaining lives
//   player_r       player radius, feeds aR of every position block
//   game_over      high in OVER
//   win            valid in OVER: 1 = score target reached, 0 = out of lives
module game_state_ctrl #(
    parameter int R_INIT        = 10,
    parameter int R_STEP        = 2,
    parameter int R_MAX         = 40,
    parameter int LIVES_INIT    = 3,
    parameter int WIN_SCORE     = 10,
    parameter int INVULN_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       food_collide,
    input  logic [3:0] enemy_collide,
    output logic       gamemenu,
    output logic       gamerun,
    output logic       gamepause,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [9:0] player_r,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [1:0] {
        S_MENU  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [7:0]  LP_WIN_SCORE = 8'(WIN_SCORE);
    localparam logic [1:0]  LP_LIVES     = 2'(LIVES_INIT);
    localparam logic [9:0]  LP_R_INIT    = 10'(R_INIT);
    localparam logic [26:0] LP_INVULN    = 27'(INVULN_CYCLES);

    // Score increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc_score(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end
        return v + 8'd1;
    endfunction

    // Radius growth clamped to R_MAX.
    function automatic logic [9:0] grow_radius(input logic [9:0] r);
        logic [10:0] sum;
        sum = {1'b0, r} + 11'(R_STEP);
        if (sum > 11'(R_MAX)) begin
            return 10'(R_MAX);
        end
        return sum[9:0];
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_start_prev, r_pause_prev, r_food_prev;
    logic [3:0]  r_enemy_prev;
    logic [7:0]  r_score,  w_score_nxt;
    logic [1:0]  r_lives,  w_lives_nxt;
    logic [9:0]  r_radius, w_radius_nxt;
    logic [26:0] r_invuln, w_invuln_nxt;
    logic        r_win,    w_win_nxt;
    logic        r_gamemenu, r_gamerun, r_gamepause, r_game_over;

    logic w_start_ev, w_pause_ev, w_food_ev, w_enemy_ev;

    assign w_start_ev = btn_start & ~r_start_prev;
    assign w_pause_ev = btn_pause & ~r_pause_prev;
    assign w_food_ev  = food_collide & ~r_food_prev;
    // Simultaneous edges on several enemy bits collapse into one hit.
    assign w_enemy_ev = |(enemy_collide & ~r_enemy_prev);

    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_radius_nxt = r_radius;
        w_invuln_nxt = r_invuln;
        w_win_nxt    = r_win;

        case (r_state)
            S_MENU: begin
                w_score_nxt  = 8'd0;
                w_lives_nxt  = LP_LIVES;
                w_radius_nxt = LP_R_INIT;
                w_invuln_nxt = 27'd0;
                w_win_nxt    = 1'b0;
                if (w_start_ev) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (w_food_ev) begin
                    w_score_nxt  = sat_inc_score(r_score);
                    w_radius_nxt = grow_radius(r_radius);
                end
                if (r_invuln != 27'd0) begin
                    w_invuln_nxt = r_invuln - 27'd1;
                end
                // A counter at 1 reaches 0 on this edge, so a hit on that
                // cycle is already accepted.
                if (w_enemy_ev && (r_invuln <= 27'd1)) begin
                    w_lives_nxt  = r_lives - 2'd1;
                    w_invuln_nxt = LP_INVULN;
                end
                // Loss outranks win, and both outrank a pause request.
                if (w_lives_nxt == 2'd0) begin
                    w_state_nxt = S_OVER;
                    w_win_nxt   = 1'b0;
                end else if (w_score_nxt >= LP_WIN_SCORE) begin
                    w_state_nxt = S_OVER;
                    w_win_nxt   = 1'b1;
                end else if (w_pause_ev) begin
                    w_state_nxt = S_PAUSE;
                end
            end

            S_PAUSE: begin
                if (w_pause_ev) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_OVER: begin
                // Reinitialise on the same edge so MENU is clean on entry.
                if (w_start_ev) begin
                    w_state_nxt  = S_MENU;
                    w_score_nxt  = 8'd0;
                    w_lives_nxt  = LP_LIVES;
                    w_radius_nxt = LP_R_INIT;
                    w_invuln_nxt = 27'd0;
                    w_win_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_MENU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_MENU;
            // Prev registers start high so inputs held through reset
            // release do not register as edges.
            r_start_prev <= 1'b1;
            r_pause_prev <= 1'b1;
            r_food_prev  <= 1'b1;
            r_enemy_prev <= 4'hF;
            r_score      <= 8'd0;
            r_lives      <= LP_LIVES;
            r_radius     <= LP_R_INIT;
            r_invuln     <= 27'd0;
            r_win        <= 1'b0;
            r_gamemenu   <= 1'b1;
            r_gamerun    <= 1'b0;
            r_gamepause  <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_prev <= btn_start;
            r_pause_prev <= btn_pause;
            r_food_prev  <= food_collide;
            r_enemy_prev <= enemy_collide;
            r_score      <= w_score_nxt;
            r_lives      <= w_lives_nxt;
            r_radius     <= w_radius_nxt;
            r_invuln     <= w_invuln_nxt;
            r_win        <= w_win_nxt;
            r_gamemenu   <= (w_state_nxt == S_MENU);
            r_gamerun    <= (w_state_nxt == S_RUN);
            r_gamepause  <= (w_state_nxt == S_PAUSE);
            r_game_over  <= (w_state_nxt == S_OVER);
        end
    end

    assign gamemenu  = r_gamemenu;
    assign gamerun   = r_gamerun;
    assign gamepause = r_gamepause;
    assign game_over = r_game_over;
    assign score     = r_score;
    assign lives     = r_lives;
    assign player_r  = r_radius;
    assign win       = r_win;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

    localparam int INV = 8;
    localparam int M_MENU = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b1;
    logic       btn_pause = 1'b0;
    logic       food_collide = 1'b0;
    logic [3:0] enemy_collide = 4'h0;

    logic       gamemenu, gamerun, gamepause, game_over, win;
    logic [7:0] score;
    logic [1:0] lives;
    logic [9:0] player_r;

    logic       b_menu, b_run, b_pause, b_over, b_win;
    logic [7:0] b_score;
    logic [1:0] b_lives;
    logic [9:0] b_player_r;

    game_state_ctrl #(.INVULN_CYCLES(INV)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
        .food_collide(food_collide), .enemy_collide(enemy_collide),
        .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
        .score(score), .lives(lives), .player_r(player_r),
        .game_over(game_over), .win(win)
    );

    // Second instance only used to observe radius saturation.
    game_state_ctrl #(.INVULN_CYCLES(INV), .R_INIT(36)) dut_big (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
        .food_collide(food_collide), .enemy_collide(enemy_collide),
        .gamemenu(b_menu), .gamerun(b_run), .gamepause(b_pause),
        .score(b_score), .lives(b_lives), .player_r(b_player_r),
        .game_over(b_over), .win(b_win)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: game rules in plain integers. Invulnerability is
    // tracked as the number of RUN cycles elapsed since the last hit.
    int   m_mode, m_score, m_lives, m_r, m_since;
    bit   m_win, m_valid;
    bit   p_s, p_p, p_f;
    logic [3:0] p_e;
    bit   es, ep, ef, ee;

    initial m_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = M_MENU; m_score = 0; m_lives = 3; m_r = 10; m_win = 0;
            m_since = INV; p_s = 1; p_p = 1; p_f = 1; p_e = 4'hF; m_valid = 1;
        end else begin
            es = btn_start && !p_s;
            ep = btn_pause && !p_p;
            ef = food_collide && !p_f;
            ee = (enemy_collide & ~p_e) != 4'h0;
            case (m_mode)
                M_MENU: begin
                    m_score = 0; m_lives = 3; m_r = 10; m_win = 0; m_since = INV;
                    if (es) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (ef) begin
                        if (m_score < 255) m_score = m_score + 1;
                        m_r = (m_r + 2 > 40) ? 40 : m_r + 2;
                    end
                    if (ee && (m_since + 1 >= INV)) begin
                        m_lives = m_lives - 1;
                        m_since = 0;
                    end else if (m_since < INV) begin
                        m_since = m_since + 1;
                    end
                    if (m_lives == 0) begin
                        m_mode = M_OVER; m_win = 0;
                    end else if (m_score >= 10) begin
                        m_mode = M_OVER; m_win = 1;
                    end else if (ep) begin
                        m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (ep) m_mode = M_RUN;
                default: begin
                    if (es) begin
                        m_mode = M_MENU; m_score = 0; m_lives = 3; m_r = 10;
                        m_win = 0; m_since = INV;
                    end
                end
            endcase
            p_s = btn_start; p_p = btn_pause; p_f = food_collide; p_e = enemy_collide;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gamemenu",  gamemenu,  m_mode == M_MENU);
            chk("model_gamerun",   gamerun,   m_mode == M_RUN);
            chk("model_gamepause", gamepause, m_mode == M_PAUSE);
            chk("model_game_over", game_over, m_mode == M_OVER);
            chk("model_score",     score,     m_score);
            chk("model_lives",     lives,     m_lives);
            chk("model_player_r",  player_r,  m_r);
            chk("model_win",       win,       m_win);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int r_big_exp[3];

    initial begin
        r_big_exp = '{38, 40, 40};
        // 1: reset with start held, no edge on release
        cyc(3);
        chk("rst_gamemenu", gamemenu, 1);
        chk("rst_lives", lives, 3);
        chk("rst_player_r", player_r, 10);
        chk("rst_score", score, 0);
        rst_n = 1'b1;
        cyc(5);
        chk("start_held_menu", gamemenu, 1);
        chk("start_held_norun", gamerun, 0);
        btn_start = 1'b0; cyc(1);
        btn_start = 1'b1; cyc(1);
        chk("start_edge_run", gamerun, 1);
        btn_start = 1'b0;

        // 2: three long food pulses
        for (int k = 0; k < 3; k++) begin
            food_collide = 1'b1; cyc(1);
            chk("big_radius_sat", b_player_r, r_big_exp[k]);
            cyc(19);
            food_collide = 1'b0; cyc(2);
        end
        chk("food_score3", score, 3);
        chk("food_radius16", player_r, 16);

        // 3: double enemy edge = one hit, then invulnerability window
        enemy_collide = 4'b0101; cyc(1);
        chk("hit_lives2", lives, 2);
        enemy_collide = 4'b0000; cyc(3);
        enemy_collide = 4'b0010; cyc(1);
        chk("invuln_ignored", lives, 2);
        enemy_collide = 4'b0000; cyc(3);
        enemy_collide = 4'b0001; cyc(1);
        chk("hit_after_window", lives, 1);
        enemy_collide = 4'b0000;

        // 4: pause freezes invulnerability countdown
        cyc(3);
        btn_pause = 1'b1; cyc(1);
        chk("pause_entered", gamepause, 1);
        btn_pause = 1'b0; cyc(5);
        enemy_collide = 4'b1000; cyc(2);
        enemy_collide = 4'b0000; cyc(10);
        chk("pause_lives", lives, 1);
        chk("pause_score", score, 3);
        chk("pause_still", gamepause, 1);
        btn_pause = 1'b1; cyc(1);
        chk("resume_run", gamerun, 1);
        btn_pause = 1'b0; cyc(2);
        enemy_collide = 4'b0100; cyc(1);
        chk("resume_invuln", lives, 1);
        enemy_collide = 4'b0000;

        // 5: food and fatal hit in the same cycle: loss wins
        for (int k = 0; k < 6; k++) begin
            food_collide = 1'b1; cyc(1);
            food_collide = 1'b0; cyc(1);
        end
        chk("score9", score, 9);
        food_collide = 1'b1; enemy_collide = 4'b0100; cyc(1);
        chk("loss_over", game_over, 1);
        chk("loss_win0", win, 0);
        chk("loss_score", score, 10);
        chk("loss_lives", lives, 0);
        chk("loss_modes", {gamemenu, gamerun, gamepause}, 0);
        food_collide = 1'b0; enemy_collide = 4'b0000;
        btn_pause = 1'b1; cyc(1);
        btn_pause = 1'b0; cyc(1);
        chk("over_pause_ignored", game_over, 1);

        // 6: restart to MENU, then reset mid-RUN
        btn_start = 1'b1; cyc(1);
        chk("restart_menu", gamemenu, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_radius", player_r, 10);
        chk("restart_over", game_over, 0);
        btn_start = 1'b0; cyc(1);
        btn_start = 1'b1; cyc(1);
        btn_start = 1'b0;
        chk("second_run", gamerun, 1);
        food_collide = 1'b1; cyc(1);
        food_collide = 1'b0;
        chk("second_score", score, 1);
        rst_n = 1'b0; cyc(1);
        chk("midrun_rst_menu", gamemenu, 1);
        chk("midrun_rst_score", score, 0);
        chk("midrun_rst_radius", player_r, 10);
        rst_n = 1'b1; cyc(1);

        // Win path; start ignored in RUN, pause ignored on the winning cycle
        btn_start = 1'b1; cyc(1);
        btn_start = 1'b0; cyc(1);
        btn_start = 1'b1; cyc(1);
        chk("start_in_run_ignored", gamerun, 1);
        btn_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            food_collide = 1'b1; cyc(1);
            food_collide = 1'b0; cyc(1);
        end
        food_collide = 1'b1; btn_pause = 1'b1; cyc(1);
        chk("win_over", game_over, 1);
        chk("win_flag", win, 1);
        chk("win_score", score, 10);
        chk("win_no_pause", gamepause, 0);
        chk("win_radius", player_r, 30);
        food_collide = 1'b0; btn_pause = 1'b0; cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
